// File: rtl/ncpu32k_cell_tdpram_sclk.sv
// ncpu32k_cell_tdpram_sclk
// Single-clock true dual-port RAM. Each port has per-byte write enables.
// Same-cycle collisions resolve the same way every time, and a read sees
// writes made to the same address in the same cycle by either port.
// An output pipeline register can be added, and an optional sequencer can
// clear the array in hardware.
//
// Optional feature macro: NCPU32K_TDPRAM_CLEAR_EN
//   When defined, a CLEAR/READY FSM zeroes the whole array after reset.
//   The busy output is high while it runs.
//   When undefined, busy is tied low and the array is not initialised.
//
// Parameters:
//   AW    address width, depth = 2^AW words
//   DW    data width, a multiple of 8
//   OREG  0: read latency 1; 1: extra output register, read latency 2
//
// Ports:
//   clk     core clock, all logic acts on the rising edge
//   rst     asynchronous active-high reset; clears the output, pipeline and
//           control registers, but not the array contents
//   en_a    port A access enable
//   addr_a  port A address
//   we_a    port A byte write enables
//   din_a   port A write data
//   dout_a  port A read data
//   en_b, addr_b, we_b, din_b, dout_b   the same signals for port B
//   coll    one-cycle pulse: in the previous cycle both ports wrote
//           overlapping bytes of the same address
//   busy    clear sequencer is active; all port requests are ignored
module ncpu32k_cell_tdpram_sclk #(
  parameter int AW   = 8,
  parameter int DW   = 32,
  parameter int OREG = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_a,
  input  logic [AW-1:0]   addr_a,
  input  logic [DW/8-1:0] we_a,
  input  logic [DW-1:0]   din_a,
  output logic [DW-1:0]   dout_a,
  input  logic            en_b,
  input  logic [AW-1:0]   addr_b,
  input  logic [DW/8-1:0] we_b,
  input  logic [DW-1:0]   din_b,
  output logic [DW-1:0]   dout_b,
  output logic            coll,
  output logic            busy
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;

`ifdef NCPU32K_TDPRAM_CLEAR_EN
  // Clear sequencer. Reset parks it in CLEAR at address 0.
  // It writes one zero word per cycle.
  // After the last address it hands the array over to the ports.
  typedef enum logic {CLEAR, READY} clr_state_t;

  clr_state_t    state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    busy        = 1'b0;
    case (state)
      CLEAR: begin
        busy        = 1'b1;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == {AW{1'b1}})
          state_nxt = READY;
      end
      READY: begin
        busy = 1'b0;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  assign clr_we   = busy;
  assign clr_addr = clr_cnt;
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  // Effective byte writes. While the sequencer is busy, all port
  // writes are dropped.
  logic [NB-1:0] wr_a, wr_b;
  logic          same_addr;
  logic          ld_a, ld_b;

  assign wr_a      = {NB{en_a & ~busy}} & we_a;
  assign wr_b      = {NB{en_b & ~busy}} & we_b;
  assign same_addr = en_a & en_b & (addr_a == addr_b);
  assign ld_a      = en_a & ~busy;
  assign ld_b      = en_b & ~busy;

  // Post-write read value for each port, built byte by byte.
  // If both ports address the same word, each one sees the final stored
  // value, and port A wins any byte that both ports write.
  // Otherwise a port only merges its own write into the old word.
  logic [DW-1:0] old_a, old_b, rd_a, rd_b;

  assign old_a = mem[addr_a];
  assign old_b = mem[addr_b];

  always_comb begin
    rd_a = old_a;
    rd_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (wr_a[i])
        rd_a[i*8 +: 8] = din_a[i*8 +: 8];
      else if (same_addr && wr_b[i])
        rd_a[i*8 +: 8] = din_b[i*8 +: 8];

      if (same_addr && wr_a[i])
        rd_b[i*8 +: 8] = din_a[i*8 +: 8];
      else if (wr_b[i])
        rd_b[i*8 +: 8] = din_b[i*8 +: 8];
    end
  end

  // Array update. Port B is applied first so that port A overrides any
  // byte both ports write to the same address.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int i = 0; i < NB; i++)
        if (wr_b[i])
          mem[addr_b][i*8 +: 8] <= din_b[i*8 +: 8];
      for (int i = 0; i < NB; i++)
        if (wr_a[i])
          mem[addr_a][i*8 +: 8] <= din_a[i*8 +: 8];
    end
  end

  // Stage-1 read registers. They load only on an accepted access.
  // Otherwise they hold, so the output stays frozen while en is low.
  logic [DW-1:0] s1_a, s1_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a <= '0;
      s1_b <= '0;
    end else begin
      if (ld_a) s1_a <= rd_a;
      if (ld_b) s1_b <= rd_b;
    end
  end

  // Collision flag. This is a registered, one-cycle report of overlapping
  // same-address byte writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      coll <= 1'b0;
    else
      coll <= same_addr & (|(wr_a & wr_b));
  end

  generate
    if (OREG != 0) begin : g_oreg
      // Stage 2 follows stage 1 one cycle behind. It loads only when
      // stage 1 was loaded on the previous edge.
      logic [DW-1:0] s2_a, s2_b;
      logic          ld_a_q, ld_b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_a   <= '0;
          s2_b   <= '0;
          ld_a_q <= 1'b0;
          ld_b_q <= 1'b0;
        end else begin
          ld_a_q <= ld_a;
          ld_b_q <= ld_b;
          if (ld_a_q) s2_a <= s1_a;
          if (ld_b_q) s2_b <= s1_b;
        end
      end

      assign dout_a = s2_a;
      assign dout_b = s2_b;
    end else begin : g_direct
      assign dout_a = s1_a;
      assign dout_b = s1_b;
    end
  endgenerate

endmodule
